// File: rtl/demux_1to16_deser.sv
// Receive-side 1-to-16 deserializer: steers serial bits into a 16-bit staging word by `sel` or an
// auto-increment pointer, then publishes it with an out_valid pulse. Optional: DEMUX_LIVE_OUT_EN.
module demux_1to16_deser #(
    parameter int unsigned NBITS = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             auto_sel,
    input  logic             clear,
    output logic [NBITS-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             err
);

    localparam logic StIdle = 1'b0;
    localparam logic StFill = 1'b1;

    if (NBITS != 16 || SEL_W != $clog2(NBITS)) begin : g_bad_params
        $error("demux_1to16_deser: NBITS must be 16 and SEL_W must be log2(NBITS)");
    end

    logic             state_q, state_d;
    logic [NBITS-1:0] stage_q, stage_d;
    logic [NBITS-1:0] mask_q, mask_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             mode_q, mode_d;
    logic [NBITS-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic             wr_mode;
    logic [SEL_W-1:0] wr_idx;
    logic [NBITS-1:0] wr_stage;
    logic [NBITS-1:0] wr_mask;
    logic             wr_dup;

    // Candidate write: the mode comes straight from auto_sel on the first bit of a word.
    always_comb begin
        wr_mode          = (state_q == StIdle) ? auto_sel : mode_q;
        wr_idx           = wr_mode ? ptr_q : sel;
        wr_stage         = stage_q;
        wr_stage[wr_idx] = in;
        wr_mask          = mask_q;
        wr_mask[wr_idx]  = 1'b1;
        wr_dup           = !wr_mode && mask_q[wr_idx];
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        mode_d      = mode_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;

        if (clear) begin
            // Clear also swallows any bit presented alongside it.
            if (state_q == StFill) begin
                state_d = StIdle;
                stage_d = '0;
                mask_d  = '0;
                ptr_d   = '0;
            end
        end else if (in_valid) begin
`ifdef DEMUX_LIVE_OUT_EN
            out_d = wr_stage;
`endif
            if (wr_dup) begin
                stage_d = wr_stage;
                err_d   = 1'b1;
            end else if (&wr_mask) begin
                state_d     = StIdle;
                out_d       = wr_stage;
                out_valid_d = 1'b1;
                stage_d     = '0;
                mask_d      = '0;
                ptr_d       = '0;
            end else begin
                state_d = StFill;
                stage_d = wr_stage;
                mask_d  = wr_mask;
                if (wr_mode) begin
                    ptr_d = ptr_q + SEL_W'(1);
                end
                if (state_q == StIdle) begin
                    mode_d = auto_sel;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            mask_q      <= '0;
            ptr_q       <= '0;
            mode_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == StFill);
    assign err       = err_q;

endmodule
